// File: rtl/conv_pkg.sv
// Shared types and constants for the convolution datapath blocks.
package conv_pkg;

   localparam int DATA_WIDTH = 32;

   typedef logic [DATA_WIDTH-1:0] data_t;

   typedef enum logic {ACCUM, DONE} psum_state_t;

endpackage

// File: rtl/adder_tmp.sv
// Two-input combinational adder; the result wraps modulo 2^WIDTH.
module adder_tmp #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/psum_accumulator.sv
// Accumulates ACC_LEN adder-tree partial sums plus a per-group bias into one
// output-pixel sum, presented on a valid/ready port with backpressure.
module psum_accumulator
   import conv_pkg::*;
#(
   parameter int WIDTH   = DATA_WIDTH,
   parameter int ACC_LEN = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [WIDTH-1:0] bias,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             busy
);

   localparam int CNT_W = $clog2(ACC_LEN + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_LEN - 1);

   psum_state_t      state;
   psum_state_t      state_next;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] addend;
   logic [WIDTH-1:0] sum;
   logic [CNT_W-1:0] cnt;
   logic             accept;
   logic             consume;
   logic             last_beat;

   // In DONE a new beat can only enter if the pending result leaves this cycle.
   assign in_ready  = rst && !clear && ((state == ACCUM) || out_ready);
   assign accept    = in_valid && in_ready;
   assign consume   = out_valid && out_ready;
   assign last_beat = (cnt == LAST_CNT);
   assign busy      = (cnt != '0);

   // The bias replaces the (empty) accumulator on the first beat of a group.
   assign addend = (cnt == '0) ? bias : acc;

   adder_tmp #(
      .WIDTH(WIDTH)
   ) u_adder (
      .a  (addend),
      .b  (in_data),
      .sum(sum)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= ACCUM;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: DONE is left on consume unless the accepted beat completes another group.
   always_comb begin
      state_next = state;
      case (state)
         ACCUM: begin
            if (accept && last_beat) begin
               state_next = DONE;
            end
         end
         DONE: begin
            if (accept) begin
               state_next = last_beat ? DONE : ACCUM;
            end else if (consume) begin
               state_next = ACCUM;
            end
         end
         default: state_next = ACCUM;
      endcase
   end

   // Accumulator, beat counter and registered output; an accept may overwrite a same-cycle consume.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc       <= '0;
         cnt       <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
      end else begin
         if (consume) begin
            out_valid <= 1'b0;
         end
         if (clear) begin
            acc <= '0;
            cnt <= '0;
         end else if (accept) begin
            if (last_beat) begin
               out_data  <= sum;
               out_valid <= 1'b1;
               acc       <= '0;
               cnt       <= '0;
            end else begin
               acc <= sum;
               cnt <= cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_psum_accumulator.sv
// Testbench for psum_accumulator: a 4-beat instance and a 1-beat instance,
// with queue scoreboards fed by the stimulus and drained by output monitors.
module tb_psum_accumulator;

   typedef struct packed {
      logic [31:0]      bias;
      logic [3:0][31:0] d;
      logic [31:0]      expected;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        clear;
   logic [31:0] bias;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        busy;

   logic        one_clear;
   logic [31:0] one_bias;
   logic        one_in_valid;
   logic        one_in_ready;
   logic [31:0] one_in_data;
   logic        one_out_valid;
   logic        one_out_ready;
   logic [31:0] one_out_data;
   logic        one_busy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] q4[$];
   logic [31:0] q1[$];
   vec_t        vecs[5];

   psum_accumulator #(.WIDTH(32), .ACC_LEN(4)) dut4 (
      .clk(clk), .rst(rst), .clear(clear), .bias(bias),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .busy(busy)
   );

   psum_accumulator #(.WIDTH(32), .ACC_LEN(1)) dut1 (
      .clk(clk), .rst(rst), .clear(one_clear), .bias(one_bias),
      .in_valid(one_in_valid), .in_ready(one_in_ready), .in_data(one_in_data),
      .out_valid(one_out_valid), .out_ready(one_out_ready), .out_data(one_out_data),
      .busy(one_busy)
   );

   // Free-running clock.
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one beat into the 4-beat instance and wait (bounded) until it is accepted.
   task automatic applyStimulus(input logic [31:0] b, input logic [31:0] d, output int waited);
      bit got = 0;
      bias     = b;
      in_data  = d;
      in_valid = 1'b1;
      waited   = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready) begin
            got = 1;
            break;
         end
         waited++;
      end
      if (got) begin
         @(posedge clk);
         #1;
      end else begin
         n_checks++;
         n_errors++;
         $display("[TB] FAIL accept_timeout: beat 0x%08h not accepted within 20 cycles", d);
      end
      in_valid = 1'b0;
   endtask

   // One full group; bias is garbage after the first beat to prove it is sampled only once.
   task automatic runGroup(input logic [31:0] b, input logic [3:0][31:0] d);
      int w;
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 0) ? b : 32'hDEAD_BEEF, d[i], w);
      end
   endtask

   // Scoreboard for the 4-beat instance: compare every consumed result.
   always @(negedge clk) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (q4.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL dut4_unexpected: got 0x%08h, expected no result", out_data);
         end else begin
            checkOutput("dut4_result", out_data, q4.pop_front());
         end
      end
   end

   // Scoreboard for the 1-beat instance.
   always @(negedge clk) begin
      if (one_out_valid === 1'b1 && one_out_ready === 1'b1) begin
         if (q1.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("[TB] FAIL dut1_unexpected: got 0x%08h, expected no result", one_out_data);
         end else begin
            checkOutput("dut1_result", one_out_data, q1.pop_front());
         end
      end
   end

   initial begin
      int w;
      vecs[0] = '{bias: 32'd10,         d: {32'd4, 32'd3, 32'd2, 32'd1},          expected: 32'd20};
      vecs[1] = '{bias: 32'd0,          d: {32'd5, 32'd0, 32'd1, 32'hFFFF_FFFF},  expected: 32'd5};
      vecs[2] = '{bias: 32'd100,        d: {32'd5, 32'd5, 32'd5, 32'd5},          expected: 32'd120};
      vecs[3] = '{bias: 32'hFFFF_FFFE,  d: {32'd0, 32'd0, 32'd0, 32'd1},          expected: 32'hFFFF_FFFF};
      vecs[4] = '{bias: 32'd7,          d: {32'd0, 32'd0, 32'd0, 32'd0},          expected: 32'd7};

      rst = 1'b0; clear = 1'b0; bias = '0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
      one_clear = 1'b0; one_bias = '0; one_in_valid = 1'b0; one_in_data = '0; one_out_ready = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset_out_data", out_data, 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset_one_out_valid", 32'(one_out_valid), 32'd0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] basic group with latency and busy");
      q4.push_back(32'd20);
      for (int i = 0; i < 4; i++) begin
         applyStimulus((i == 0) ? 32'd10 : 32'hDEAD_BEEF, 32'(i + 1), w);
         if (i < 3) checkOutput("busy_mid_group", 32'(busy), 32'd1);
      end
      checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
      checkOutput("latency_out_data", out_data, 32'd20);
      checkOutput("busy_after_last", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("out_valid_drops", 32'(out_valid), 32'd0);

      $display("[TB] table-driven groups");
      for (int v = 0; v < 5; v++) begin
         q4.push_back(vecs[v].expected);
         runGroup(vecs[v].bias, vecs[v].d);
      end
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] backpressure");
      out_ready = 1'b0;
      q4.push_back(32'd20);
      runGroup(32'd10, {32'd4, 32'd3, 32'd2, 32'd1});
      for (int c = 0; c < 5; c++) begin
         checkOutput("bp_out_valid", 32'(out_valid), 32'd1);
         checkOutput("bp_out_data", out_data, 32'd20);
         checkOutput("bp_in_ready", 32'(in_ready), 32'd0);
         @(posedge clk);
         #1;
      end
      out_ready = 1'b1;
      q4.push_back(32'd23);
      applyStimulus(32'd10, 32'd7, w);
      checkOutput("bp_same_cycle_accept", 32'(w), 32'd0);
      checkOutput("bp_out_valid_cleared", 32'(out_valid), 32'd0);
      checkOutput("bp_busy_new_group", 32'(busy), 32'd1);
      applyStimulus(32'hDEAD_BEEF, 32'd1, w);
      applyStimulus(32'hDEAD_BEEF, 32'd2, w);
      applyStimulus(32'hDEAD_BEEF, 32'd3, w);
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] clear");
      applyStimulus(32'd0, 32'd1, w);
      applyStimulus(32'hDEAD_BEEF, 32'd2, w);
      clear = 1'b1; in_valid = 1'b1; in_data = 32'd9;
      @(negedge clk);
      checkOutput("clear_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      checkOutput("clear_busy", 32'(busy), 32'd0);
      clear = 1'b0; in_valid = 1'b0;
      q4.push_back(32'd16);
      runGroup(32'd0, {32'd4, 32'd4, 32'd4, 32'd4});
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] reset mid-group and with a pending result");
      applyStimulus(32'd0, 32'd1, w);
      applyStimulus(32'hDEAD_BEEF, 32'd2, w);
      checkOutput("pre_reset_busy", 32'(busy), 32'd1);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_mid_busy", 32'(busy), 32'd0);
      checkOutput("rst_mid_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_in_ready", 32'(in_ready), 32'd0);
      rst = 1'b1;
      out_ready = 1'b0;
      runGroup(32'd0, {32'd3, 32'd3, 32'd3, 32'd3});
      checkOutput("pending_out_valid", 32'(out_valid), 32'd1);
      checkOutput("pending_out_data", out_data, 32'd12);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("rst_pending_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_pending_out_data", out_data, 32'd0);
      checkOutput("rst_pending_busy", 32'(busy), 32'd0);
      rst = 1'b1;
      out_ready = 1'b1;
      q4.push_back(32'd4);
      runGroup(32'd0, {32'd1, 32'd1, 32'd1, 32'd1});
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] ACC_LEN=1 back-to-back");
      for (int i = 0; i < 3; i++) q1.push_back(32'(7 + i));
      for (int i = 0; i < 3; i++) begin
         one_bias = 32'd2;
         one_in_data = 32'(5 + i);
         one_in_valid = 1'b1;
         @(negedge clk);
         checkOutput("one_in_ready", 32'(one_in_ready), 32'd1);
         @(posedge clk);
         #1;
         checkOutput("one_out_valid", 32'(one_out_valid), 32'd1);
         checkOutput("one_out_data", one_out_data, 32'(7 + i));
      end
      one_in_valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("one_out_valid_drops", 32'(one_out_valid), 32'd0);

      repeat (3) @(posedge clk);
      #1;
      checkOutput("q4_drained", 32'(q4.size()), 32'd0);
      checkOutput("q1_drained", 32'(q1.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always terminates.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/psum_accumulator.md
Name: psum_accumulator

Overview:
- Sits directly downstream of the 4-input adder tree in the convolution datapath.
- Each beat carries one adder-tree partial sum, typically 4 products of one input channel.
- Accumulates ACC_LEN consecutive beats, plus a bias sampled on the first beat, into one output-pixel sum.
- Presents that sum on a valid/ready output port with backpressure; a new group may begin in the same cycle the previous result is consumed.

Parameters:
- WIDTH, 32, data width of partial sums, bias and result; all arithmetic wraps modulo 2^WIDTH.
- ACC_LEN, 4, beats per group; legal range 1..65535.
- CNT_W, $clog2(ACC_LEN+1), localparam; beat counter width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- clear  in  1  synchronous abort of the partial accumulation in progress.
- bias  in  WIDTH  bias added once per group; sampled on the group's first accepted beat.
- in_valid  in  1  upstream partial sum valid.
- in_ready  out  1  block can accept in_data this cycle.
- in_data  in  WIDTH  partial sum from the adder tree.
- out_valid  out  1  out_data holds a completed group sum.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  WIDTH  completed group sum.
- busy  out  1  a group is partially accumulated (cnt != 0).

Behaviour:
- Reset: when rst==0 at posedge, the following are cleared:
  - state=ACCUM, acc=0, cnt=0, out_valid=0, out_data=0.
  - in_ready is combinational and is 0 while rst==0.
- Reset mid-group or with out_valid high discards all data; no partial result is emitted.
- Handshake:
  - An input beat is accepted when in_valid && in_ready.
  - An output is consumed when out_valid && out_ready.
  - out_data and out_valid are registered and stay stable while out_valid && !out_ready.
- in_ready = rst && !clear && (state==ACCUM || out_ready).
  - This gives combinational pass-through of out_ready in DONE.
  - There is no combinational path from in_valid to in_ready.
- Accept-beat sum: sum = (cnt==0 ? bias : acc) + in_data, truncated to WIDTH bits.
- State ACCUM, on an accepted beat:
  - If cnt==ACC_LEN-1: out_data<=sum, out_valid<=1, acc<=0, cnt<=0, go to DONE.
  - Otherwise: acc<=sum, cnt<=cnt+1.
- State DONE, with out_valid=1 and no beat accepted:
  - On consume: out_valid<=0, go to ACCUM.
  - Otherwise hold.
- State DONE, consume and accept in the same cycle: the beat is processed as in ACCUM.
  - If ACC_LEN==1, the new result overwrites out_data, out_valid stays 1, state stays DONE.
  - Otherwise out_valid<=0, go to ACCUM with acc=bias+in_data, cnt=1.
- Latency: the result is visible on out_data one cycle after the group's last beat is accepted. Throughput is 1 beat/cycle when out_ready is high.
- clear:
  - Sets acc<=0 and cnt<=0. in_ready is forced to 0, so a beat with clear==1 is never accepted.
  - A pending result (out_valid, out_data) is unaffected; the consume path still operates while clear is high.
- busy = (cnt!=0).
- Overflow wraps silently with no flag. Signedness is irrelevant because all operations are two's-complement add.

Decomposition:
- Package conv_pkg holds:
  - localparam DATA_WIDTH=32 (default for WIDTH).
  - typedef logic [DATA_WIDTH-1:0] data_t.
  - typedef enum logic {ACCUM, DONE} psum_state_t.
- Sub-module: the single WIDTH-bit add reuses the team's existing two-input combinational adder adder_tmp. There is no other sub-module.
- The counter and FSM stay inline.

Test Plan:
- Reset, then ACC_LEN=4, bias=10, in_data 1,2,3,4 on consecutive cycles, out_ready=1 -> out_valid=1 for one cycle, 1 cycle after beat 4, out_data=20; busy high after beats 1-3.
- Backpressure: the same group with out_ready=0 for 5 cycles -> out_data=20 held stable, in_ready=0 throughout. Raising out_ready with in_valid high and in_data=7 -> result consumed and next group starts (acc=bias+7, cnt=1) in the same cycle.
- Wrap: bias=0, in_data 0xFFFF_FFFF,1,0,5 -> out_data=0x0000_0005.
- clear after 2 beats (1,2), then beats 4,4,4,4, bias=0 -> out_data=16. A beat presented with clear=1 is not accepted (in_ready=0).
- rst=0 asserted mid-group and again while out_valid=1 -> out_valid=0, out_data=0, busy=0 next cycle. A following group of 1,1,1,1 with bias=0 -> out_data=4.
- ACC_LEN=1, bias=2, in_data 5,6,7 back-to-back, out_ready=1 -> out_data 7,8,9 on successive cycles with out_valid held 1.
